// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the data-memory port. Takes load/store requests from the
//   core (byte address plus RV32 funct3), drives a word-indexed data memory
//   with combinational read and posedge write, and returns one completion
//   pulse per request. The memory only stores whole words, so SB/SH are done
//   as read-modify-write. Loads are lane-extracted and sign/zero extended.
//   Misaligned, out-of-range and illegal-funct3 requests fault without
//   touching memory.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE, out of reset)
//   req_store             1 = store, 0 = load
//   req_funct3            000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr              byte address
//   req_wdata             store data (low byte/half for SB/SH)
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data, 0 for stores and faults
//   resp_err              00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
//   mem_read, mem_write   memory enables (never both high)
//   mem_addr              word index (req_addr >> 2)
//   mem_wdata             word to write
//   mem_rdata             memory read data, valid in the same cycle as mem_read
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                state, state_next;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_word_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            err_q;

  logic                  f3_illegal;
  logic                  f3_misaligned;
  logic                  f3_range;
  logic [1:0]            fault_code;
  logic [ADDR_WIDTH-1:0] req_word_idx;

  // Pick the addressed byte or half out of a memory word and extend it.
  // funct3[2] selects zero extension (BU/HU); W passes straight through.
  function automatic logic [DATA_WIDTH-1:0] extract_load(
    input logic [DATA_WIDTH-1:0] word,
    input logic [2:0]            f3,
    input logic [1:0]            lane
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract_load = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  extract_load = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  extract_load = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  extract_load = {{(DATA_WIDTH-16){1'b0}}, h};
      default: extract_load = word;
    endcase
  endfunction

  // Replace the addressed byte (SB) or half (SH) of the old word with the
  // low bits of the store data.
  function automatic logic [DATA_WIDTH-1:0] merge_store(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_data,
    input logic [2:0]            f3,
    input logic [1:0]            lane
  );
    merge_store = old_word;
    if (f3[1:0] == 2'b00) begin
      case (lane)
        2'd0:    merge_store[7:0]   = new_data[7:0];
        2'd1:    merge_store[15:8]  = new_data[7:0];
        2'd2:    merge_store[23:16] = new_data[7:0];
        default: merge_store[31:24] = new_data[7:0];
      endcase
    end else begin
      if (lane[1]) merge_store[31:16] = new_data[15:0];
      else         merge_store[15:0]  = new_data[15:0];
    end
  endfunction

  // Fault classification of the incoming request; the priority order
  // illegal > misaligned > range is resolved in fault_code.
  always_comb begin
    req_word_idx  = {2'b00, req_addr[ADDR_WIDTH-1:2]};
    f3_illegal    = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                    || (req_store && req_funct3[2]);
    f3_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                    || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    f3_range      = req_word_idx >= ADDR_WIDTH'(DATA_DEPTH);
    fault_code    = 2'b00;
    if (f3_illegal)         fault_code = 2'b11;
    else if (f3_misaligned) fault_code = 2'b01;
    else if (f3_range)      fault_code = 2'b10;
  end

  // Next-state and memory-side decode. Enables and address are derived only
  // from the state and the latched request, so reset clears them at once.
  always_comb begin
    state_next = state;
    req_ready  = (state == S_IDLE) && !reset;
    resp_valid = (state == S_RESP);
    mem_read   = (state == S_LOAD) || (state == S_RMW_RD);
    mem_write  = (state == S_WRITE);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (mem_read || mem_write) mem_addr = {2'b00, addr_q[ADDR_WIDTH-1:2]};
    if (mem_write)             mem_wdata = wr_word_q;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (fault_code != 2'b00)      state_next = S_RESP;
          else if (!req_store)          state_next = S_LOAD;
          else if (req_funct3 == 3'b010) state_next = S_WRITE;
          else                          state_next = S_RMW_RD;
        end
      end
      S_LOAD:   state_next = S_RESP;
      S_RMW_RD: state_next = S_WRITE;
      S_WRITE:  state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State register and request latches. wr_word_q starts as the raw store
  // data (used directly by SW) and is overwritten with the merged word
  // during the read half of a read-modify-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      funct3_q  <= '0;
      addr_q    <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
      err_q     <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wr_word_q <= req_wdata;
            rdata_q   <= '0;
            err_q     <= fault_code;
          end
        end
        S_LOAD:   rdata_q   <= extract_load(mem_rdata, funct3_q, addr_q[1:0]);
        S_RMW_RD: wr_word_q <= merge_store(mem_rdata, wr_word_q, funct3_q, addr_q[1:0]);
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, expected responses
// queued at request time and compared when resp_valid is seen.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:31];
  int          tests;
  int          failures;
  int          cyc;
  int          accept_cyc;
  int          rd_cnt;
  int          wr_cnt;
  int          both_cnt;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DATA_DEPTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_store(req_store),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write on the rising edge.
  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr < 32) mem_rdata = mem[mem_addr[4:0]];
  end

  always @(posedge clk) begin
    if (mem_write && mem_addr < 32) mem[mem_addr[4:0]] = mem_wdata;
  end

  // Cycle counter plus the cycle number of the most recent accept edge.
  always @(posedge clk) begin
    if (req_valid && req_ready) accept_cyc = cyc;
    cyc = cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Memory activity monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
    if (mem_read && mem_write) both_cnt++;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("resp_rdata", resp_rdata, e.rdata);
        checkOutput("resp_err", 32'(resp_err), 32'(e.err));
        checkOutput("resp_latency", 32'(cyc - accept_cyc), 32'(e.lat));
      end
    end
  end

  // Issue one request, queue its expected response, wait for completion and
  // check the number of memory read/write cycles it caused.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic [1:0] exp_err, input int exp_lat);
    exp_t e;
    int   n;
    int   reads_exp;
    int   writes_exp;
    if (exp_err != 2'b00)  begin reads_exp = 0; writes_exp = 0; end
    else if (!st)          begin reads_exp = 1; writes_exp = 0; end
    else if (f3 == 3'b010) begin reads_exp = 0; writes_exp = 1; end
    else                   begin reads_exp = 1; writes_exp = 1; end
    rd_cnt = 0;
    wr_cnt = 0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    exp_q.push_back(e);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("resp_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    checkOutput("mem_read_cycles", 32'(rd_cnt), 32'(reads_exp));
    checkOutput("mem_write_cycles", 32'(wr_cnt), 32'(writes_exp));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] data;
    int          idx;
    tests = 0; failures = 0; cyc = 0; accept_cyc = 0;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    last_wr_addr = '0; last_wr_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = {8'hA5, 8'(i), 16'h0F0F};
    mem[1] = 32'h0000_0055;
    mem[2] = 32'h1122_3344;
    mem[3] = 32'h8000_00F0;
    reset = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

    // Loads with extraction and extension
    applyStimulus(1'b0, 3'b000, 32'h0C, 32'h0, 32'hFFFF_FFF0, 2'b00, 2);
    applyStimulus(1'b0, 3'b101, 32'h0E, 32'h0, 32'h0000_8000, 2'b00, 2);
    applyStimulus(1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF_8000, 2'b00, 2);
    applyStimulus(1'b0, 3'b100, 32'h0F, 32'h0, 32'h0000_0080, 2'b00, 2);
    applyStimulus(1'b0, 3'b000, 32'h0F, 32'h0, 32'hFFFF_FF80, 2'b00, 2);
    applyStimulus(1'b0, 3'b010, 32'h0C, 32'h0, 32'h8000_00F0, 2'b00, 2);
    applyStimulus(1'b0, 3'b001, 32'h0C, 32'h0, 32'h0000_00F0, 2'b00, 2);

    // Sub-word stores via read-modify-write
    applyStimulus(1'b1, 3'b000, 32'h09, 32'h0000_00AB, 32'h0, 2'b00, 3);
    checkOutput("sb_wr_addr", last_wr_addr, 32'd2);
    checkOutput("sb_wr_data", last_wr_data, 32'h1122_AB44);
    checkOutput("sb_mem2", mem[2], 32'h1122_AB44);
    applyStimulus(1'b1, 3'b001, 32'h0A, 32'hFFFF_5566, 32'h0, 2'b00, 3);
    applyStimulus(1'b0, 3'b010, 32'h08, 32'h0, 32'h5566_AB44, 2'b00, 2);

    // Faults and their priority
    applyStimulus(1'b1, 3'b010, 32'h06, 32'h1234_5678, 32'h0, 2'b01, 1);
    applyStimulus(1'b0, 3'b001, 32'h01, 32'h0, 32'h0, 2'b01, 1);
    applyStimulus(1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 2'b10, 1);
    applyStimulus(1'b0, 3'b010, 32'h7C, 32'h0, 32'hA51F_0F0F, 2'b00, 2);
    applyStimulus(1'b1, 3'b101, 32'h10, 32'h0, 32'h0, 2'b11, 1);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 2'b11, 1);
    applyStimulus(1'b0, 3'b011, 32'h81, 32'h0, 32'h0, 2'b11, 1);
    applyStimulus(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 2'b11, 1);
    applyStimulus(1'b1, 3'b010, 32'h82, 32'h0, 32'h0, 2'b01, 1);

    // Word store/load round trips at random in-range indices
    for (int i = 0; i < 6; i++) begin
      idx  = int'($urandom_range(4, 31));
      data = $urandom;
      applyStimulus(1'b1, 3'b010, 32'(idx * 4), data, 32'h0, 2'b00, 2);
      applyStimulus(1'b0, 3'b010, 32'(idx * 4), 32'h0, data, 2'b00, 2);
    end

    // Reset asserted while an SW to word 1 is in its write cycle
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h04; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("rst_mid_in_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mid_mem1", mem[1], 32'h0000_0055);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mid_ready_after", 32'(req_ready), 32'd1);
    checkOutput("rst_mid_mem1_after", mem[1], 32'h0000_0055);
    checkOutput("read_write_overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
